// File: rtl/note_seq_pkg.sv
// Shared encodings for the note gate sequencer: play modes, pingpong direction
// and FSM state.
package note_seq_pkg;

  localparam logic [1:0] MODE_UP       = 2'd0;
  localparam logic [1:0] MODE_DOWN     = 2'd1;
  localparam logic [1:0] MODE_PINGPONG = 2'd2;
  localparam logic [1:0] MODE_HOLD     = 2'd3;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_GATE = 2'd2,
    ST_WAIT = 2'd3
  } seq_state_t;

endpackage

// File: rtl/seq_step_next.sv
// Combinational next step index and pingpong direction for one accepted tick.
// Endpoints are not repeated in pingpong; any non-pingpong mode resets direction to up.
module seq_step_next
  import note_seq_pkg::*;
#(
  parameter int NUM_STEPS = 16,
  parameter int IDX_W     = $clog2(NUM_STEPS)
) (
  input  logic [IDX_W-1:0] i_idx,
  input  logic             i_dir,
  input  logic [1:0]       i_mode,
  input  logic             i_first,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_dir
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_STEPS - 1);
  localparam logic [IDX_W-1:0] ZERO = '0;
  localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

  always_comb begin
    o_idx = i_idx;
    o_dir = DIR_UP;
    if (i_first) begin
      o_idx = (i_mode == MODE_DOWN) ? LAST : ZERO;
    end else begin
      case (i_mode)
        MODE_UP:   o_idx = (i_idx == LAST) ? ZERO : i_idx + ONE;
        MODE_DOWN: o_idx = (i_idx == ZERO) ? LAST : i_idx - ONE;
        MODE_PINGPONG: begin
          if (i_dir == DIR_UP) begin
            if (i_idx == LAST) begin
              o_idx = i_idx - ONE;
              o_dir = DIR_DOWN;
            end else begin
              o_idx = i_idx + ONE;
            end
          end else begin
            if (i_idx == ZERO) begin
              o_idx = ONE;
            end else begin
              o_idx = i_idx - ONE;
              o_dir = DIR_DOWN;
            end
          end
        end
        default: o_idx = i_idx;
      endcase
    end
  end

endmodule

// File: rtl/note_gate_sequencer.sv
// Step-tick driven gate sequencer feeding the ADSR bank; a one-cycle GAP before
// every gate guarantees a fresh rising edge even when the same step repeats.
//   IDLE | disabled, outputs low, next run restarts the pattern
//   GAP  | one cycle after an accepted tick, new index, strobe high
//   GATE | trigger[step_idx] high while the gate counter runs (or legato)
//   WAIT | gate finished or step muted, waiting for the next tick
module note_gate_sequencer
  import note_seq_pkg::*;
#(
  parameter int NUM_STEPS = 16,
  parameter int IDX_W     = $clog2(NUM_STEPS),
  parameter int GATE_W    = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_step_tick,
  input  logic [1:0]           i_mode,
  input  logic [NUM_STEPS-1:0] i_step_mask,
  input  logic [GATE_W-1:0]    i_gate_len,
  output logic [NUM_STEPS-1:0] o_trigger,
  output logic [IDX_W-1:0]     o_step_idx,
  output logic                 o_step_strobe
);

  seq_state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt, w_step_idx;
  logic                 r_dir, w_dir_nxt, w_step_dir;
  logic                 r_first, w_first_nxt;
  logic [GATE_W-1:0]    r_cnt, w_cnt_nxt;
  logic [NUM_STEPS-1:0] r_trigger, w_trig_nxt;
  logic                 r_strobe, w_strobe_nxt;
  logic                 w_tick_acc;

  seq_step_next #(
    .NUM_STEPS(NUM_STEPS),
    .IDX_W    (IDX_W)
  ) u_step_next (
    .i_idx  (r_idx),
    .i_dir  (r_dir),
    .i_mode (i_mode),
    .i_first(r_first),
    .o_idx  (w_step_idx),
    .o_dir  (w_step_dir)
  );

  assign w_tick_acc = i_step_tick && i_enable &&
                      ((r_state == ST_GATE) || (r_state == ST_WAIT));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_dir     <= DIR_UP;
      r_first   <= 1'b1;
      r_cnt     <= '0;
      r_trigger <= '0;
      r_strobe  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_dir     <= w_dir_nxt;
      r_first   <= w_first_nxt;
      r_cnt     <= w_cnt_nxt;
      r_trigger <= w_trig_nxt;
      r_strobe  <= w_strobe_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_dir_nxt   = r_dir;
    w_first_nxt = r_first;
    w_cnt_nxt   = r_cnt;
    if (!i_enable) begin
      w_state_nxt = ST_IDLE;
      w_first_nxt = 1'b1;
    end else if (w_tick_acc) begin
      w_state_nxt = ST_GAP;
      w_idx_nxt   = w_step_idx;
      w_dir_nxt   = w_step_dir;
      w_first_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_WAIT;
          w_first_nxt = 1'b1;
        end
        ST_GAP: begin
          if (i_step_mask[r_idx]) begin
            w_state_nxt = ST_GATE;
            w_cnt_nxt   = i_gate_len;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end
        ST_GATE: begin
          // A zero count means legato: hold until the next accepted tick.
          if (r_cnt == GATE_W'(1)) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = '0;
          end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - GATE_W'(1);
          end
        end
        ST_WAIT: w_state_nxt = ST_WAIT;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_trig_nxt = '0;
    if (w_state_nxt == ST_GATE) begin
      w_trig_nxt[w_idx_nxt] = 1'b1;
    end
    w_strobe_nxt = (w_state_nxt == ST_GAP);
  end

  assign o_trigger     = r_trigger;
  assign o_step_idx    = r_idx;
  assign o_step_strobe = r_strobe;

endmodule

// File: tb/tb_note_gate_sequencer.sv
// Bench for note_gate_sequencer: directed scenarios with literal expectations plus
// randomized stimulus, all cross-checked each cycle against a behavioural model.
module tb_note_gate_sequencer;

  localparam int N  = 16;
  localparam int IW = 4;
  localparam int GW = 8;

  logic          clk  = 1'b0;
  logic          rst  = 1'b1;
  logic          en   = 1'b0;
  logic          tick = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [N-1:0]  mask = '1;
  logic [GW-1:0] glen = 8'd3;
  logic [N-1:0]  trig;
  logic [IW-1:0] sidx;
  logic          strb;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  note_gate_sequencer #(
    .NUM_STEPS(N),
    .IDX_W    (IW),
    .GATE_W   (GW)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_enable     (en),
    .i_step_tick  (tick),
    .i_mode       (mode),
    .i_step_mask  (mask),
    .i_gate_len   (glen),
    .o_trigger    (trig),
    .o_step_idx   (sidx),
    .o_step_strobe(strb)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: running flag, gap flag and remaining gate-high cycles
  // (-1 = legato), updated once per clock from the pre-edge inputs.
  bit m_run = 1'b0, m_gap = 1'b0, m_up = 1'b1, m_first = 1'b1;
  int m_rem = 0, m_idx = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_run = 1'b0; m_gap = 1'b0; m_up = 1'b1; m_first = 1'b1; m_rem = 0; m_idx = 0;
    end else if (!en) begin
      m_run = 1'b0; m_gap = 1'b0; m_rem = 0; m_first = 1'b1;
    end else if (!m_run) begin
      m_run = 1'b1;
    end else if (m_gap) begin
      m_gap = 1'b0;
      m_rem = mask[m_idx] ? ((glen == '0) ? -1 : int'(glen)) : 0;
    end else if (tick) begin
      if (m_first) begin
        m_idx = (mode == 2'd1) ? N - 1 : 0;
        m_up = 1'b1;
        m_first = 1'b0;
      end else begin
        case (mode)
          2'd0: m_idx = (m_idx + 1) % N;
          2'd1: m_idx = (m_idx + N - 1) % N;
          2'd2: begin
            if (m_up) begin
              if (m_idx == N - 1) begin m_idx = N - 2; m_up = 1'b0; end
              else m_idx++;
            end else begin
              if (m_idx == 0) begin m_idx = 1; m_up = 1'b1; end
              else m_idx--;
            end
          end
          default: ;
        endcase
        if (mode != 2'd2) m_up = 1'b1;
      end
      m_gap = 1'b1;
      m_rem = 0;
    end else if (m_rem > 0) begin
      m_rem--;
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] et;
    if (cmp_en) begin
      et = (m_rem != 0) ? (N'(1) << m_idx) : '0;
      chk("model_trigger", 32'(trig), 32'(et));
      chk("model_step_idx", 32'(sidx), 32'(m_idx));
      chk("model_step_strobe", 32'(strb), 32'(m_gap));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_once();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
  endtask

  initial begin
    int hi;
    int lo;
    int e;
    rst = 1'b1;
    cyc(1);
    cmp_en = 1'b1;
    cyc(1);
    chk("reset_trigger", 32'(trig), 32'd0);
    chk("reset_idx", 32'(sidx), 32'd0);
    chk("reset_strobe", 32'(strb), 32'd0);

    // UP, gate length 3, ticks every 8 cycles
    rst = 1'b0; en = 1'b1; mode = 2'd0; mask = '1; glen = 8'd3;
    cyc(2);
    for (int k = 0; k < 17; k++) begin
      tick_once();
      chk("up_strobe", 32'(strb), 32'd1);
      chk("up_idx", 32'(sidx), 32'(k % 16));
      cyc(1);
      chk("up_rise", 32'(trig), 32'd1 << (k % 16));
      hi = int'(trig != '0);
      for (int j = 0; j < 6; j++) begin
        cyc(1);
        hi += int'(trig != '0);
      end
      chk("up_gate_len", 32'(hi), 32'd3);
    end

    // HOLD legato: one low cycle per tick
    mode = 2'd3; glen = 8'd0;
    for (int k = 0; k < 4; k++) begin
      tick_once();
      chk("hold_idx", 32'(sidx), 32'd0);
      lo = int'(trig == '0);
      for (int j = 0; j < 3; j++) begin
        cyc(1);
        lo += int'(trig == '0);
      end
      chk("hold_gap_cycles", 32'(lo), 32'd1);
    end

    // DOWN from reset
    rst = 1'b1; cyc(2); rst = 1'b0; mode = 2'd1; glen = 8'd2; cyc(2);
    for (int k = 0; k < 17; k++) begin
      tick_once();
      chk("down_idx", 32'(sidx), 32'((15 - k + 16) % 16));
      cyc(3);
    end

    // PINGPONG from reset
    rst = 1'b1; cyc(2); rst = 1'b0; mode = 2'd2; glen = 8'd1; cyc(2);
    for (int k = 0; k < 32; k++) begin
      tick_once();
      e = (k < 16) ? k : ((k <= 30) ? 30 - k : k - 30);
      chk("pingpong_idx", 32'(sidx), 32'(e));
      cyc(2);
    end

    // Muted first step
    rst = 1'b1; cyc(2); rst = 1'b0; mode = 2'd0; mask = 16'hFFFE; glen = 8'd2; cyc(2);
    tick_once();
    chk("mask_strobe", 32'(strb), 32'd1);
    chk("mask_idx", 32'(sidx), 32'd0);
    cyc(1);
    chk("mask_silent", 32'(trig), 32'd0);
    cyc(2);
    chk("mask_silent_late", 32'(trig), 32'd0);
    tick_once();
    chk("mask_idx2", 32'(sidx), 32'd1);
    cyc(1);
    chk("mask_rise", 32'(trig), 32'h0002);

    // Back-to-back ticks: second lands in GAP and is dropped
    mask = '1; cyc(3);
    tick = 1'b1; cyc(2); tick = 1'b0;
    chk("drop_idx", 32'(sidx), 32'd2);
    chk("drop_trigger", 32'(trig), 32'h0004);
    cyc(4);

    // Disable mid-gate, then restart
    glen = 8'd10;
    tick_once();
    cyc(3);
    chk("gate_mid", 32'(trig), 32'h0008);
    en = 1'b0; cyc(1);
    chk("disable_trigger", 32'(trig), 32'd0);
    chk("disable_idx", 32'(sidx), 32'd3);
    cyc(2);
    en = 1'b1; cyc(2);
    tick_once();
    chk("reenable_idx", 32'(sidx), 32'd0);
    cyc(1);
    chk("reenable_trigger", 32'(trig), 32'h0001);

    // Reset mid-gate
    cyc(2);
    rst = 1'b1; cyc(1);
    chk("midgate_reset_trigger", 32'(trig), 32'd0);
    chk("midgate_reset_idx", 32'(sidx), 32'd0);
    chk("midgate_reset_strobe", 32'(strb), 32'd0);
    rst = 1'b0; cyc(2);

    // Maximum gate length
    glen = 8'd255;
    tick_once();
    chk("len255_idx", 32'(sidx), 32'd0);
    hi = 0;
    for (int i = 0; i < 300; i++) begin
      cyc(1);
      hi += int'(trig != '0);
    end
    chk("len255_cycles", 32'(hi), 32'd255);

    // Randomized run against the model
    for (int c = 0; c < 4000; c++) begin
      rst  = ($urandom_range(0, 499) == 0);
      en   = ($urandom_range(0, 59) != 0);
      tick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) mask = N'($urandom);
      glen = ($urandom_range(0, 3) == 0) ? 8'd0 : GW'($urandom_range(1, 5));
      cyc(1);
    end
    rst = 1'b0; en = 1'b1; tick = 1'b0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_gate_sequencer.md
# note_gate_sequencer

Parametrised step-trigger generator driving per-voice ADSR gates: walks a NUM_STEPS-position pattern on external step ticks and produces a one-hot gate vector whose rising edge is note-on and falling edge is note-off. Adds programmable gate length, per-step mute mask, four play modes and a guaranteed release gap, so every step, including a repeated one, yields a fresh rising edge. Sits between the tempo/step-tick source and the ADSR bank.

## Interface
- NUM_STEPS, 16, pattern length and gate vector width; 2..256.
- IDX_W, $clog2(NUM_STEPS), width of step index.
- GATE_W, 8, width of gate-length field.

- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  run when high; low forces IDLE.
- step_tick  in  1  single-cycle advance pulse.
- mode  in  2  0 UP, 1 DOWN, 2 PINGPONG, 3 HOLD; sampled on each accepted tick.
- step_mask  in  NUM_STEPS  1 = step sounds, 0 = muted (index advances, no gate).
- gate_len  in  GATE_W  gate-high cycles; 0 = legato, held until next tick or disable.
- trigger  out  NUM_STEPS  one-hot gate, registered.
- step_idx  out  IDX_W  current position, registered.
- step_strobe  out  1  one-cycle pulse when step_idx updates.

## Operation
- States: IDLE, GAP, GATE, WAIT.
- IDLE: trigger all 0; `first` flag set. Exits to WAIT when enable=1.
- Accepted tick = step_tick & enable in GATE or WAIT → compute next index, go GAP.
- GAP (exactly 1 cycle): trigger all 0, step_idx = new, step_strobe=1. Next: GATE if step_mask[step_idx] and enable, else WAIT.
- GATE: trigger[step_idx]=1, all other bits 0. Counter loads gate_len on entry, decrements each cycle; at 1 → WAIT (high for exactly gate_len cycles). gate_len=0: stay until next accepted tick.
- WAIT: trigger all 0.
- Next index: if `first`, UP/PINGPONG/HOLD → 0, DOWN → NUM_STEPS-1; clear `first`. Else UP: +1, wraps NUM_STEPS-1→0. DOWN: -1, wraps 0→NUM_STEPS-1. PINGPONG: bounce without repeating endpoints (…N-2, N-1, N-2…, 1, 0, 1…); direction flag forced to "up" whenever mode≠PINGPONG. HOLD: unchanged.
- Tick during GAP or IDLE: ignored, not queued.
- enable falling in any state: next cycle IDLE, trigger 0, step_idx retained, `first` set (next run restarts at 0/N-1).
- gate_len changes apply at next GATE entry only; step_mask is sampled in GAP only.

## Timing
- Reset (sync): state IDLE, trigger 0, step_idx 0, step_strobe 0, counter 0, direction up, `first`=1.
- Tick sampled at edge t → GAP at t+1 (step_strobe=1, new step_idx) → trigger[step_idx] rises at t+2.
- Minimum tick spacing for sounding steps: 2 cycles; closer ticks land in GAP and are dropped.
- Gate falls at t+2+gate_len; a tick arriving while still in GATE truncates the gate (falls at t'+1).
- All outputs registered; no combinational input-to-output path.

## Structure
- Package note_seq_pkg: mode encodings (MODE_UP, MODE_DOWN, MODE_PINGPONG, MODE_HOLD), state encoding.
- Sub-module seq_step_next: combinational next-index/next-direction from (idx, dir, mode, first); unit-testable for wrap and bounce.
- Top holds FSM, gate counter, output registers.

## Test plan
- Reset, enable=1, mode UP, mask all 1, gate_len 3, tick every 8 cycles → step_idx 0,1,…,15,0; trigger[k] high exactly 3 cycles starting 2 cycles after each tick.
- Mode HOLD, gate_len 0, ticks every 4 cycles → step_idx stays 0; trigger[0] drops for exactly 1 cycle (GAP) per tick.
- NUM_STEPS=4, PINGPONG → indices 0,1,2,3,2,1,0,1; DOWN from reset → 3,2,1,0,3.
- step_mask=16'hFFFE: first tick → step_strobe, step_idx 0, trigger stays 0; second tick → trigger[1] rises.
- Ticks 1 cycle apart → second tick dropped; enable low mid-GATE → trigger 0 next cycle, re-enable + tick → step 0.
- Reset asserted mid-GATE → next cycle all outputs at reset values; gate_len 255 → exactly 255 high cycles.
